// File: rtl/bcd_stream_arbiter.sv
// Round-robin arbiter over N_CLIENTS binary sources feeding a sequential double-dabble BCD converter.
// Latency: ack one cycle after capture, out_valid DATA_WIDTH cycles after capture; no skid after transfer.
// Backpressure: result held in HOLD until ready; requests wait unlatched. BCD_LEADING_ZERO_BLANK_EN enables blanking.
module bcd_stream_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] client_data,
    input  logic [N_CLIENTS-1:0]            v,
    input  logic                            reverse_order,
    output logic [N_CLIENTS-1:0]            ack,
    input  logic                            ready,
    output logic                            out_valid,
    output logic [NUM_DIGITS*4-1:0]         digits,
    output logic [$clog2(N_CLIENTS)-1:0]    client_id,
    output logic                            overflow,
    output logic                            busy
);
    localparam int BW = NUM_DIGITS * 4;
    localparam int PW = $clog2(N_CLIENTS);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    function automatic longint unsigned max_bcd_value(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

    localparam longint unsigned          MAXV   = max_bcd_value(NUM_DIGITS);
    localparam logic [DATA_WIDTH-1:0]    MAXV_W = DATA_WIDTH'(MAXV);
    localparam logic [CW-1:0]            LAST   = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         grant;
    logic [DATA_WIDTH-1:0] word;
    logic                  over;
    logic [BW-1:0]         bcd;
    logic [DATA_WIDTH-1:0] bin;
    logic [CW-1:0]         cnt;
    logic                  rev;
    logic [BW+DATA_WIDTH-1:0] step_q;
    int                    idx;

    // One add-3 correction pass followed by a one-bit left shift of {bcd, bin}.
    function automatic logic [BW+DATA_WIDTH-1:0] dd_step(input logic [BW-1:0] b,
                                                         input logic [DATA_WIDTH-1:0] x);
        logic [BW-1:0]            a;
        logic [BW+DATA_WIDTH-1:0] c;
        a = b;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (a[k*4 +: 4] >= 4'd5) a[k*4 +: 4] = a[k*4 +: 4] + 4'd3;
        c = {a, x};
        return {c[BW+DATA_WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [BW-1:0] format_digits(input logic [BW-1:0] b, input logic rv);
        logic [BW-1:0] r;
        logic [BW-1:0] o;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic          lead;
`endif
        r = b;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        // Units digit is excluded so a zero result still shows a single 0.
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && r[k*4 +: 4] == 4'd0) r[k*4 +: 4] = 4'hF;
            else                             lead = 1'b0;
        end
`endif
        o = r;
        if (rv)
            for (int k = 0; k < NUM_DIGITS; k++) o[k*4 +: 4] = r[(NUM_DIGITS-1-k)*4 +: 4];
        return o;
    endfunction

    // Highest offset first so the nearest set request above rr_ptr wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_CLIENTS;
            if (v[idx]) grant = PW'(idx);
        end
    end

    assign word   = client_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign over   = 64'(word) > MAXV;
    assign step_q = dd_step(bcd, bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (|v) state_nxt = CONVERT;
            CONVERT: if (cnt == LAST) state_nxt = HOLD;
            HOLD:    if (ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            out_valid <= 1'b0;
            digits    <= '0;
            client_id <= '0;
            overflow  <= 1'b0;
            rr_ptr    <= '0;
            bcd       <= '0;
            bin       <= '0;
            cnt       <= '0;
            rev       <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (|v) begin
                    ack       <= N_CLIENTS'(1) << grant;
                    bin       <= over ? MAXV_W : word;
                    overflow  <= over;
                    rev       <= reverse_order;
                    client_id <= grant;
                    rr_ptr    <= (grant == PW'(N_CLIENTS - 1)) ? '0 : grant + 1'b1;
                    bcd       <= '0;
                    cnt       <= '0;
                end
                CONVERT: begin
                    bcd <= step_q[BW+DATA_WIDTH-1 -: BW];
                    bin <= step_q[DATA_WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        digits    <= format_digits(step_q[BW+DATA_WIDTH-1 -: BW], rev);
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_stream_arbiter.sv
// Scoreboard bench: stimulus pushes expected results from a decimal-arithmetic model, a monitor pops on transfer.
module tb_bcd_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] client_data = '0;
    logic [3:0]  v = '0;
    logic        reverse_order = 1'b0;
    logic [3:0]  ack;
    logic        ready = 1'b1;
    logic        out_valid;
    logic [11:0] digits;
    logic [1:0]  client_id;
    logic        overflow;
    logic        busy;

    logic [23:0] s_data = '0;
    logic [1:0]  s_v = '0;
    logic        s_rev = 1'b0;
    logic [1:0]  s_ack;
    logic        s_out_valid;
    logic [11:0] s_digits;
    logic [0:0]  s_id;
    logic        s_overflow;
    logic        s_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int m_rr = 0;
    bit rr_mode = 0;
    bit gap_mode = 0;
    int cap_cyc = 0;
    int last_ack = -1;
    int xfer_cyc = -1;

    typedef struct packed {
        logic [11:0] dig;
        logic [1:0]  id;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    bcd_stream_arbiter #(.N_CLIENTS(4), .DATA_WIDTH(8), .NUM_DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .client_data(client_data), .v(v),
        .reverse_order(reverse_order), .ack(ack), .ready(ready), .out_valid(out_valid),
        .digits(digits), .client_id(client_id), .overflow(overflow), .busy(busy));

    bcd_stream_arbiter #(.N_CLIENTS(2), .DATA_WIDTH(12), .NUM_DIGITS(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .client_data(s_data), .v(s_v),
        .reverse_order(s_rev), .ack(s_ack), .ready(1'b1), .out_valid(s_out_valid),
        .digits(s_digits), .client_id(s_id), .overflow(s_overflow), .busy(s_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Decimal digits of the saturated value; reversed order puts the hundreds digit in slot 0.
    function automatic logic [11:0] model_digits(input int val, input bit rv);
        int d0, d1, d2;
        d0 = val % 10;
        d1 = (val / 10) % 10;
        d2 = (val / 100) % 10;
        return rv ? {4'(d0), 4'(d1), 4'(d2)} : {4'(d2), 4'(d1), 4'(d0)};
    endfunction

    function automatic int pick(input logic [3:0] vv);
        for (int i = 0; i < 4; i++)
            if (vv[(m_rr + i) % 4]) return (m_rr + i) % 4;
        return 0;
    endfunction

    task automatic wait_ack(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 300);
        chk("ack_grant", 64'(ack), 64'(1) << g);
    endtask

    task automatic issue(input logic [3:0] vv, input bit rv, input logic [31:0] dat, input bit keep);
        int   g, w;
        exp_t e;
        client_data   = dat;
        v             = vv;
        reverse_order = rv;
        g     = pick(vv);
        w     = int'(dat[g*8 +: 8]);
        e.dig = model_digits((w > 999) ? 999 : w, rv);
        e.id  = 2'(g);
        e.ovf = (w > 999);
        exp_q.push_back(e);
        m_rr  = (g + 1) % 4;
        wait_ack(g);
        if (!keep) v = 4'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    logic [3:0]  prev_ack = '0;
    logic        prev_ov = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [14:0] prev_bundle = '0;

    always @(negedge clk) begin
        exp_t e;
        if (ack != 4'b0) begin
            chk("ack_single_cycle", 64'(prev_ack), 64'(0));
            chk("ack_not_in_hold", 64'(out_valid), 64'(0));
            if (rr_mode && last_ack >= 0) chk("rr_spacing", 64'(cyc - last_ack), 64'(10));
            if (gap_mode && xfer_cyc >= 0) chk("xfer_to_grant", 64'(cyc - xfer_cyc), 64'(2));
            cap_cyc  = cyc;
            last_ack = cyc;
        end
        if (out_valid && !prev_ov) chk("out_latency", 64'(cyc - cap_cyc), 64'(8));
        if (out_valid && prev_ov && !prev_rdy)
            chk("hold_stable", 64'({digits, client_id, overflow}), 64'(prev_bundle));
        if (out_valid && ready) begin
            xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'({digits, client_id}), 64'(14'h3FFF) + 64'(1));
            end else begin
                e = exp_q.pop_front();
                chk("digits", 64'(digits), 64'(e.dig));
                chk("client_id", 64'(client_id), 64'(e.id));
                chk("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
        prev_ack    = ack;
        prev_ov     = out_valid;
        prev_rdy    = ready;
        prev_bundle = {digits, client_id, overflow};
    end

    int   sat_words[6] = '{1234, 999, 1000, 57, 4095, 0};
    bit   sat_revs[6]  = '{0, 0, 1, 1, 0, 0};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_digits", 64'(digits), 64'(0));
        chk("rst_client_id", 64'(client_id), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Single request: client 2 holds 255.
        issue(4'b0100, 1'b0, 32'h00FF_0000, 1'b0);
        drain();

        // Round-robin from a fresh reset with all clients requesting.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_rr = 0;
        rr_mode = 1; last_ack = -1;
        for (int i = 0; i < 5; i++) issue(4'b1111, 1'b0, $urandom, 1'b1);
        v = 4'b0;
        drain();
        rr_mode = 0;

        // Backpressure: result held for 25 cycles, no grant meanwhile.
        rdy_mode = 0;
        @(posedge clk); #2;
        issue(4'b0011, 1'b0, $urandom, 1'b1);
        repeat (25) @(negedge clk);
        chk("bp_out_valid_held", 64'(out_valid), 64'(1));
        gap_mode = 1; xfer_cyc = -1;
        rdy_mode = 1;
        issue(4'b0011, 1'b1, client_data, 1'b0);
        gap_mode = 0;
        drain();

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++)
            issue(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
        drain();
        rdy_mode = 1;

        // Reset in the middle of a conversion discards the word and restarts priority at client 0.
        issue(4'b1001, 1'b0, $urandom, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ack", 64'(ack), 64'(0));
        chk("midrst_digits_id_ovf", 64'({digits, client_id, overflow}), 64'(0));
        void'(exp_q.pop_back());
        m_rr = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        issue(4'b1001, 1'b0, client_data, 1'b0);
        drain();

        // Saturation on a 12-bit, 3-digit instance.
        for (int i = 0; i < 6; i++) begin
            int n, c, w;
            c = i % 2;
            w = sat_words[i];
            s_data = '0;
            s_data[c*12 +: 12] = 12'(w);
            s_v   = 2'b01 << c;
            s_rev = sat_revs[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!s_out_valid && n < 100);
            chk("sat_latency", 64'(n), 64'(13));
            chk("sat_digits", 64'(s_digits), 64'(model_digits((w > 999) ? 999 : w, sat_revs[i])));
            chk("sat_overflow", 64'(s_overflow), 64'(w > 999));
            chk("sat_client_id", 64'(s_id), 64'(c));
            s_v = 2'b00;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
